// File: rtl/wb_csr_slave.sv
// wb_csr_slave: Wishbone CSR front end for a byte engine; define WB_CSR_IRQ_EN to enable the interrupt
module wb_csr_slave #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BUSES  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_o,
  output logic [7:0]            wdata_o,
  output logic [3:0]            bus_sel_o,
  input  logic                  done_i,
  input  logic [2:0]            done_stat_i,
  input  logic [7:0]            rdata_i,
  input  logic                  bb_i,
  input  logic                  bc_i,
  input  logic [7:0]            fsmr_i
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [4:0] BUS_LIMIT = 5'(NUM_BUSES);

  logic [1:0] state;
  logic       en, ie, irq, ack;
  logic [3:0] bus, stat;
  logic [2:0] cmd;
  logic [7:0] tx, rx, dat, rd_mux;
  logic       acc, wr, rd, wr_csr, wr_dpr, wr_cmdr, idle_en, cmd_go, cmd_bad, e_off, fin;

  assign acc     = cyc_i & stb_i & ~ack;
  assign wr      = acc & we_i;
  assign rd      = acc & ~we_i;
  assign wr_csr  = wr & (adr_i == 2'd0);
  assign wr_dpr  = wr & (adr_i == 2'd1);
  assign wr_cmdr = wr & (adr_i == 2'd2);
  assign idle_en = en & (state == IDLE);
  assign cmd_go  = wr_cmdr & idle_en & ~(dat_i[2] & dat_i[1]);
  assign cmd_bad = wr_cmdr & idle_en & dat_i[2] & dat_i[1];
  assign e_off   = wr_csr & ~dat_i[7];
  assign fin     = (state == WAIT) & done_i;
  assign rd_mux  = adr_i == 2'd0 ? {en, ie, bb_i, bc_i, bus} :
                   adr_i == 2'd1 ? rx :
                   adr_i == 2'd2 ? {stat, 4'b0000} : fsmr_i;

  assign dat_o       = dat;
  assign ack_o       = ack;
  assign irq_o       = irq;
  assign cmd_valid_o = state == ISSUE;
  assign cmd_o       = cmd;
  assign wdata_o     = tx;
  assign bus_sel_o   = bus;

  // Bus handshake: one-cycle ack per accepted strobe, read data only in the ack cycle
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ack <= 1'b0;
      dat <= '0;
    end else begin
      ack <= acc;
      dat <= rd ? rd_mux : '0;
    end

  // CSR enable and bus select; out-of-range bus numbers leave the selection untouched
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      en  <= 1'b0;
      bus <= '0;
    end else begin
      en  <= wr_csr ? dat_i[7] : en;
      bus <= (wr_csr && {1'b0, dat_i[3:0]} < BUS_LIMIT) ? dat_i[3:0] : bus;
    end

  // Data path: tx byte from DPR writes, rx byte captured on command completion
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      tx <= '0;
      rx <= '0;
    end else begin
      tx <= wr_dpr ? dat_i : tx;
      rx <= fin ? rdata_i : rx;
    end

  // Command FSM: dropping E abandons any command in flight
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= e_off ? IDLE :
                  state == IDLE  ? (cmd_go ? ISSUE : IDLE) :
                  state == ISSUE ? (cmd_ready_i ? WAIT : ISSUE) :
                  state == WAIT  ? (done_i ? IDLE : WAIT) : IDLE;

  // Command code and status {DON, NAK, AL, ERR}; an illegal code reports ERR alone
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cmd  <= '0;
      stat <= '0;
    end else begin
      cmd  <= cmd_go ? dat_i[2:0] : cmd;
      stat <= cmd_go ? 4'b0000 : cmd_bad ? 4'b0001 : fin ? {1'b1, done_stat_i} : stat;
    end

`ifdef WB_CSR_IRQ_EN
  logic rd_cmdr;
  assign rd_cmdr = rd & (adr_i == 2'd2);

  // Level interrupt: new DON/ERR wins over a simultaneous CMDR read, E or IE off wins over all
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      ie  <= wr_csr ? dat_i[6] : ie;
      irq <= (e_off | (wr_csr & ~dat_i[6])) ? 1'b0 :
             (ie & (fin | cmd_bad)) ? 1'b1 :
             rd_cmdr ? 1'b0 : irq;
    end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_wb_csr_slave.sv
// tb_wb_csr_slave: scoreboard bench for wb_csr_slave against a transaction-level model
module tb_wb_csr_slave;
  localparam int NB = 10;
`ifdef WB_CSR_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0, cmd_ready = 0, done = 0, bb = 0, bc = 0;
  logic [1:0] adr = 0;
  logic [7:0] dat_w = 0, rdata = 0, fsmr = 0;
  logic [2:0] done_stat = 0;
  logic [7:0] dat_o, wdata_o;
  logic       ack_o, irq_o, cmd_valid_o;
  logic [2:0] cmd_o;
  logic [3:0] bus_sel_o;

  always #5 clk = ~clk;

  wb_csr_slave #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_BUSES(NB)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat_w), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready), .cmd_o(cmd_o),
    .wdata_o(wdata_o), .bus_sel_o(bus_sel_o), .done_i(done), .done_stat_i(done_stat),
    .rdata_i(rdata), .bb_i(bb), .bc_i(bc), .fsmr_i(fsmr)
  );

  int checks = 0, failures = 0;

  typedef enum {P_NONE, P_ISSUED, P_ACCEPTED} phase_t;
  phase_t     m_phase = P_NONE;
  bit         m_e, m_ie, m_irq;
  bit   [3:0] m_bus, m_stat;
  bit   [7:0] m_tx, m_rx;
  bit   [2:0] m_cmd;
  logic [7:0] exp_q[$];
  bit         prev_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_NONE; m_e = 0; m_ie = 0; m_irq = 0;
    m_bus = 0; m_stat = 0; m_tx = 0; m_rx = 0; m_cmd = 0;
  endfunction

  function automatic logic [7:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {m_e, m_ie, bb, bc, m_bus};
      2'd1:    return m_rx;
      2'd2:    return {m_stat, 4'b0000};
      default: return fsmr;
    endcase
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [7:0] d);
    case (a)
      2'd0: begin
        if (!d[7]) m_phase = P_NONE;
        if (!d[7] || !d[6]) m_irq = 0;
        m_e  = d[7];
        m_ie = IRQ & d[6];
        if (int'(d[3:0]) < NB) m_bus = d[3:0];
      end
      2'd1: m_tx = d;
      2'd2: if (m_e && m_phase == P_NONE) begin
        if (d[2:0] <= 3'd5) begin
          m_phase = P_ISSUED; m_cmd = d[2:0]; m_stat = 0;
        end else begin
          m_stat = 4'b0001;
          if (m_ie) m_irq = 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void model_done(input logic [2:0] st, input logic [7:0] r);
    if (m_phase == P_ACCEPTED) begin
      m_stat = {1'b1, st}; m_rx = r; m_phase = P_NONE;
      if (m_ie) m_irq = 1;
    end
  endfunction

  // monitor: pops the scoreboard on every ack and compares steady-state outputs with the model
  always @(negedge clk) begin
    if (!rst) prev_ack = 0;
    else begin
      if (prev_ack) check("ack_single", ack_o, 0);
      if (ack_o) begin
        if (exp_q.size() == 0) check("ack_spurious", ack_o, 0);
        else check("dat_ack", dat_o, exp_q.pop_front());
      end else check("dat_idle", dat_o, 0);
      check("cmd_valid", cmd_valid_o, m_phase == P_ISSUED);
      if (m_phase == P_ISSUED) check("cmd_code", cmd_o, m_cmd);
      check("wdata", wdata_o, m_tx);
      check("bus_sel", bus_sel_o, m_bus);
      check("irq", irq_o, m_irq);
      prev_ack = ack_o;
    end
  end

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic access(input bit w, input logic [1:0] a, input logic [7:0] d,
                        input bit wd, input logic [2:0] st, input logic [7:0] r);
    cyc = 1; stb = 1; we = w; adr = a; dat_w = d;
    if (wd) begin done = 1; done_stat = st; rdata = r; end
    exp_q.push_back(w ? 8'h00 : model_read(a));
    @(posedge clk);
    if (w) model_write(a, d);
    else if (a == 2'd2) m_irq = 0;
    if (wd) model_done(st, r);
    @(negedge clk);
    check("ack_latency", ack_o, 1);
    cyc = 0; stb = 0; we = 0; done = 0;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    access(1, a, d, 0, 0, 0);
  endtask

  task automatic rd(input logic [1:0] a);
    access(0, a, 0, 0, 0, 0);
  endtask

  task automatic engine_accept(input int n);
    repeat (n - 1) tick();
    cmd_ready = 1;
    @(posedge clk);
    if (m_phase == P_ISSUED) m_phase = P_ACCEPTED;
    @(negedge clk);
    cmd_ready = 0;
  endtask

  task automatic engine_done(input logic [2:0] st, input logic [7:0] r);
    done = 1; done_stat = st; rdata = r;
    @(posedge clk);
    model_done(st, r);
    @(negedge clk);
    done = 0;
  endtask

  task automatic burst_fsmr();
    int acks = 0;
    fsmr = 8'($urandom);
    repeat (3) exp_q.push_back(fsmr);
    cyc = 1; stb = 1; we = 0; adr = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_o) acks++;
    end
    cyc = 0; stb = 0;
    tick();
    check("burst_acks", acks, 3);
  endtask

  task automatic reset_pulse();
    #2 rst = 0;
    #1;
    model_reset();
    exp_q.delete();
    check("rst_outputs", {ack_o, irq_o, cmd_valid_o, cmd_o, dat_o, wdata_o, bus_sel_o}, 0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
  endtask

  initial begin
    reset_pulse();
    rd(0);
    wr(0, 8'hC3);
    bb = 1; bc = 0;
    rd(0);
    wr(1, 8'h5A);
    wr(2, 8'h01);
    engine_accept(3);
    engine_done(3'b100, 8'hA5);
    tick();
    rd(2);
    rd(1);
    wr(2, 8'h07);
    rd(2);
    wr(2, 8'h02);
    engine_accept(1);
    access(0, 2, 0, 1, 3'b011, 8'h3C);
    rd(2);
    rd(1);
    wr(2, 8'h03);
    engine_accept(2);
    wr(0, 8'h00);
    engine_done(3'b111, 8'hFF);
    rd(2);
    rd(1);
    wr(2, 8'h01);
    tick();
    wr(0, 8'h80);
    engine_done(3'b001, 8'h11);
    rd(2);
    wr(0, 8'h8A);
    rd(0);
    wr(0, 8'h89);
    rd(0);
    burst_fsmr();
    wr(2, 8'h04);
    tick();
    reset_pulse();
    engine_done(3'b010, 8'h77);
    bb = 0; bc = 0;
    rd(0);
    rd(2);
    rd(1);
    wr(0, 8'hC0);
    for (int i = 0; i < 400; i++) begin
      bb = 1'($urandom); bc = 1'($urandom); fsmr = 8'($urandom);
      case ($urandom_range(0, 8))
        0: wr(0, {1'($urandom_range(0, 9) != 0), 7'($urandom)});
        1: wr(1, 8'($urandom));
        2: wr(2, 8'($urandom));
        3, 4: rd(2'($urandom));
        5: engine_accept(m_phase == P_ISSUED ? $urandom_range(1, 4) : 1);
        6: engine_done(3'($urandom), 8'($urandom));
        7: access(0, 2'($urandom), 0, 1, 3'($urandom), 8'($urandom));
        default: tick();
      endcase
    end
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
